alu_ctrl_seq: RTL and testbench

Instruction-sequencing control unit that drives the 8-bit ALU of the Mini-CPU datapath. It accepts a 14-bit PIC16-style byte-oriented instruction through a valid/ready handshake and decodes it into ALU select and control signals. It then samples the returned C/DC/Z flags into a STATUS register, issues W/file write-back strobes, and flags skip-next for INCFSZ/DECFSZ.

---
 rtl/alu_ctrl_seq_if.sv | 8 +
 rtl/alu_ctrl_seq.sv | 148 ++++++++++++++
 tb/tb_alu_ctrl_seq.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_ctrl_seq_if.sv
// alu_ctrl_seq_if: instruction valid/ready handshake between fetch and the ALU sequencer
interface alu_ctrl_seq_if;
    logic        instr_valid;
    logic [13:0] instr;
    logic        instr_ready;
    modport master (output instr_valid, output instr, input instr_ready);
    modport slave  (input instr_valid, input instr, output instr_ready);
endinterface

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: decodes PIC16-style byte instructions into ALU controls, STATUS update and write-back strobes
module alu_ctrl_seq (
    input  logic          clk,
    input  logic          rst_n,
    alu_ctrl_seq_if.slave bus,
    input  logic          alu_zero,
    input  logic          C_new,
    input  logic          DC_new,
    input  logic          stat_wr,
    input  logic [2:0]    stat_din,
    output logic          clr,
    output logic          swap_n_mov,
    output logic          rlf_n_rrf,
    output logic          sub,
    output logic [1:0]    op_mux_l,
    output logic [1:0]    op_mux_a,
    output logic [1:0]    out_mux,
    output logic          src_w,
    output logic          C_in,
    output logic [6:0]    f_addr,
    output logic          wr_w,
    output logic          wr_f,
    output logic          skip,
    output logic          illegal,
    output logic [2:0]    status
);
    typedef enum logic [2:0] {IDLE, DEC, EXE, WB, SKP} state_t;

    state_t      state_q;
    logic [10:0] ctl_q;
    logic [6:0]  f_addr_q;
    logic [2:0]  aff_q, sh_q, status_q, status_d, ext;
    logic        d_q, we_q, skt_q, legal_q, cin_q;
    logic        wr_w_q, wr_f_q, skip_q, illegal_q;
    logic [5:0]  op;
    logic [1:0]  dc_out, dc_a, dc_l;
    logic [2:0]  dc_aff;
    logic        dc_clr, dc_swap, dc_rlf, dc_sub, dc_srcw, dc_skt, dc_legal, dc_we;

    assign op = bus.instr[13:8];

    // Decode the presented opcode into ALU controls, affected flags {Z,DC,C} and instruction class
    always_comb begin
        dc_out = 2'd0;
        dc_a = 2'd0;
        dc_l = 2'd0;
        dc_clr = 1'b0;
        dc_swap = 1'b0;
        dc_rlf = 1'b0;
        dc_sub = 1'b0;
        dc_srcw = 1'b0;
        dc_aff = 3'b000;
        dc_skt = 1'b0;
        dc_legal = 1'b1;
        case (op)
            6'b000111: begin dc_out = 2'd3; dc_aff = 3'b111; end
            6'b000010: begin dc_out = 2'd3; dc_a = 2'd1; dc_sub = 1'b1; dc_aff = 3'b111; end
            6'b001010: begin dc_out = 2'd3; dc_a = 2'd2; dc_aff = 3'b100; end
            6'b000011: begin dc_out = 2'd3; dc_a = 2'd3; dc_aff = 3'b100; end
            6'b001111: begin dc_out = 2'd3; dc_a = 2'd2; dc_skt = 1'b1; end
            6'b001011: begin dc_out = 2'd3; dc_a = 2'd3; dc_skt = 1'b1; end
            6'b000100, 6'b000101, 6'b000110, 6'b001001: begin
                dc_out = 2'd2;
                dc_l = op[3] ? 2'd3 : op[1:0];
                dc_aff = 3'b100;
            end
            6'b001000: dc_aff = 3'b100;
            6'b001110: dc_swap = 1'b1;
            6'b001101: begin dc_out = 2'd1; dc_rlf = 1'b1; dc_aff = 3'b001; end
            6'b001100: begin dc_out = 2'd1; dc_aff = 3'b001; end
            6'b000001: begin dc_clr = 1'b1; dc_aff = 3'b100; end
            6'b000000: dc_srcw = bus.instr[7];
            default:   dc_legal = 1'b0;
        endcase
    end

    // NOP (opcode 0, d=0) and undecoded opcodes write nothing back
    assign dc_we = dc_legal && !(op == 6'b000000 && !bus.instr[7]);

    // External writes load STATUS; in WB the instruction's affected bits take the ALU shadows instead
    assign ext      = stat_wr ? stat_din : status_q;
    assign status_d = (state_q == WB) ? ((aff_q & sh_q) | (~aff_q & ext)) : ext;

    // Sequencer FSM with registered controls, shadows and one-cycle strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ctl_q     <= '0;
            f_addr_q  <= '0;
            aff_q     <= '0;
            sh_q      <= '0;
            status_q  <= '0;
            d_q       <= 1'b0;
            we_q      <= 1'b0;
            skt_q     <= 1'b0;
            legal_q   <= 1'b0;
            cin_q     <= 1'b0;
            wr_w_q    <= 1'b0;
            wr_f_q    <= 1'b0;
            skip_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            wr_w_q    <= 1'b0;
            wr_f_q    <= 1'b0;
            skip_q    <= 1'b0;
            illegal_q <= 1'b0;
            status_q  <= status_d;
            case (state_q)
                IDLE: if (bus.instr_valid) begin
                    ctl_q    <= {dc_out, dc_a, dc_l, dc_sub, dc_clr, dc_swap, dc_rlf, dc_srcw};
                    f_addr_q <= bus.instr[6:0];
                    d_q      <= bus.instr[7];
                    aff_q    <= dc_aff;
                    skt_q    <= dc_skt;
                    legal_q  <= dc_legal;
                    we_q     <= dc_we;
                    state_q  <= DEC;
                end
                DEC: begin
                    cin_q   <= status_q[0];
                    state_q <= EXE;
                end
                EXE: begin
                    sh_q      <= {alu_zero, DC_new, C_new};
                    wr_w_q    <= we_q & ~d_q;
                    wr_f_q    <= we_q & d_q;
                    illegal_q <= ~legal_q;
                    state_q   <= WB;
                end
                WB: begin
                    skip_q  <= skt_q & sh_q[2];
                    state_q <= (skt_q & sh_q[2]) ? SKP : IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.instr_ready = (state_q == IDLE);
    assign {out_mux, op_mux_a, op_mux_l, sub, clr, swap_n_mov, rlf_n_rrf, src_w} = ctl_q;
    assign C_in    = (state_q == EXE || state_q == WB) ? cin_q : status_q[0];
    assign f_addr  = f_addr_q;
    assign wr_w    = wr_w_q;
    assign wr_f    = wr_f_q;
    assign skip    = skip_q;
    assign illegal = illegal_q;
    assign status  = status_q;
endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb_alu_ctrl_seq: directed and randomized checks of alu_ctrl_seq against a cycle-phase reference model
module tb_alu_ctrl_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_ctrl_seq_if bus ();
    logic       alu_zero = 1'b0, C_new = 1'b0, DC_new = 1'b0, stat_wr = 1'b0;
    logic [2:0] stat_din = 3'b000;
    logic       clr, swap_n_mov, rlf_n_rrf, sub, src_w, C_in, wr_w, wr_f, skip, illegal;
    logic [1:0] op_mux_l, op_mux_a, out_mux;
    logic [6:0] f_addr;
    logic [2:0] status;

    alu_ctrl_seq dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .alu_zero(alu_zero), .C_new(C_new), .DC_new(DC_new),
        .stat_wr(stat_wr), .stat_din(stat_din),
        .clr(clr), .swap_n_mov(swap_n_mov), .rlf_n_rrf(rlf_n_rrf), .sub(sub),
        .op_mux_l(op_mux_l), .op_mux_a(op_mux_a), .out_mux(out_mux),
        .src_w(src_w), .C_in(C_in), .f_addr(f_addr),
        .wr_w(wr_w), .wr_f(wr_f), .skip(skip), .illegal(illegal), .status(status)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int hs_last = 0;
    int hs_prev = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Instruction table: {legal, writes, skip_type, aff{Z,DC,C}, out_mux, op_mux_a, op_mux_l, sub, clr, swap, rlf, src_w}
    function automatic logic [16:0] spec_row(input logic [5:0] o, input logic d);
        case (o)
            6'h07: return {3'b110, 3'b111, 11'b11_00_00_00000};
            6'h02: return {3'b110, 3'b111, 11'b11_01_00_10000};
            6'h0A: return {3'b110, 3'b100, 11'b11_10_00_00000};
            6'h03: return {3'b110, 3'b100, 11'b11_11_00_00000};
            6'h0F: return {3'b111, 3'b000, 11'b11_10_00_00000};
            6'h0B: return {3'b111, 3'b000, 11'b11_11_00_00000};
            6'h04: return {3'b110, 3'b100, 11'b10_00_00_00000};
            6'h05: return {3'b110, 3'b100, 11'b10_00_01_00000};
            6'h06: return {3'b110, 3'b100, 11'b10_00_10_00000};
            6'h09: return {3'b110, 3'b100, 11'b10_00_11_00000};
            6'h08: return {3'b110, 3'b100, 11'b00_00_00_00000};
            6'h0E: return {3'b110, 3'b000, 11'b00_00_00_00100};
            6'h0D: return {3'b110, 3'b001, 11'b01_00_00_00010};
            6'h0C: return {3'b110, 3'b001, 11'b01_00_00_00000};
            6'h01: return {3'b110, 3'b100, 11'b00_00_00_01000};
            6'h00: return d ? {3'b110, 3'b000, 11'b00_00_00_00001} : {3'b100, 3'b000, 11'b0};
            default: return 17'b0;
        endcase
    endfunction

    // Reference model: phase 0 idle, 1..3 = cycles after the handshake, 4 = taken skip
    int         m_phase = 0;
    logic [16:0] m_row = '0;
    logic [6:0] m_addr = '0;
    logic       m_d = 1'b0, m_cin = 1'b0;
    logic [2:0] m_flags = '0, m_status = '0;
    always @(posedge clk or negedge rst_n) begin
        logic [2:0] ext, nstat;
        if (!rst_n) begin
            m_phase = 0; m_row = '0; m_addr = '0; m_d = 1'b0;
            m_cin = 1'b0; m_flags = '0; m_status = '0;
        end else begin
            ext = stat_wr ? stat_din : m_status;
            nstat = (m_phase == 3) ? ((m_row[13:11] & m_flags) | (~m_row[13:11] & ext)) : ext;
            case (m_phase)
                0: if (bus.instr_valid) begin
                    m_row = spec_row(bus.instr[13:8], bus.instr[7]);
                    m_addr = bus.instr[6:0];
                    m_d = bus.instr[7];
                    m_phase = 1;
                end
                1: begin m_cin = m_status[0]; m_phase = 2; end
                2: begin m_flags = {alu_zero, DC_new, C_new}; m_phase = 3; end
                3: m_phase = (m_row[14] && m_flags[2]) ? 4 : 0;
                default: m_phase = 0;
            endcase
            m_status = nstat;
        end
    end

    // Every-cycle comparison of all DUT outputs against the model
    always @(negedge clk) begin
        logic [26:0] exp_v, dut_v;
        exp_v = {m_phase == 0, m_row[10:0], m_addr,
                 m_phase == 3 && m_row[15] && !m_d, m_phase == 3 && m_row[15] && m_d,
                 m_phase == 4, m_phase == 3 && !m_row[16], m_status,
                 (m_phase == 2 || m_phase == 3) ? m_cin : m_status[0]};
        dut_v = {bus.instr_ready, out_mux, op_mux_a, op_mux_l, sub, clr, swap_n_mov, rlf_n_rrf, src_w,
                 f_addr, wr_w, wr_f, skip, illegal, status, C_in};
        checks++;
        if (dut_v !== exp_v) begin
            errors++;
            $display("FAIL cycle %0d outputs: got %h expected %h (phase %0d)", cyc, dut_v, exp_v, m_phase);
        end
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [13:0] w);
        int n;
        n = 0;
        while (!bus.instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.instr_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: instr_ready got 0 expected 1");
        end
        bus.instr_valid = 1'b1;
        bus.instr = w;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        hs_prev = hs_last;
        hs_last = cyc;
    endtask

    initial begin
        logic [5:0] op;
        bus.instr_valid = 1'b0;
        bus.instr = '0;
        repeat (2) @(negedge clk);
        chk("reset_ready", 8'(bus.instr_ready), 8'd1);
        chk("reset_status", 8'(status), 8'd0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        // reset in the middle of ADDWF abandons the write-back
        alu_zero = 1'b1; C_new = 1'b1; DC_new = 1'b1;
        send(14'b000111_1_0000101);
        chk("addwf_faddr", 8'(f_addr), 8'h05);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_ready", 8'(bus.instr_ready), 8'd1);
        chk("midreset_status", 8'(status), 8'd0);
        chk("midreset_faddr", 8'(f_addr), 8'd0);
        @(negedge clk);
        chk("midreset_wrf", 8'(wr_f), 8'd0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("postreset_wrf", 8'(wr_f), 8'd0);
        chk("postreset_ready", 8'(bus.instr_ready), 8'd1);
        // ADDWF d=1 with all flags set
        send(14'b000111_1_0010010);
        chk("addwf_outmux", 8'(out_mux), 8'd3);
        chk("addwf_opa", 8'(op_mux_a), 8'd0);
        @(negedge clk);
        @(negedge clk);
        chk("addwf_wrf", 8'(wr_f), 8'd1);
        chk("addwf_wrw", 8'(wr_w), 8'd0);
        @(negedge clk);
        chk("addwf_status", 8'(status), 8'h7);
        // RLF with STATUS = 001
        stat_wr = 1'b1; stat_din = 3'b001;
        @(negedge clk);
        stat_wr = 1'b0;
        chk("ext_status", 8'(status), 8'h1);
        C_new = 1'b0; DC_new = 1'b1; alu_zero = 1'b1;
        send(14'b001101_1_0000011);
        chk("rlf_dir", 8'(rlf_n_rrf), 8'd1);
        chk("rlf_outmux", 8'(out_mux), 8'd1);
        @(negedge clk);
        chk("rlf_cin", 8'(C_in), 8'd1);
        @(negedge clk);
        @(negedge clk);
        chk("rlf_status", 8'(status), 8'h0);
        // DECFSZ taken skip, then not taken
        alu_zero = 1'b1;
        send(14'b001011_1_0001000);
        @(negedge clk);
        @(negedge clk);
        chk("decfsz_wrf", 8'(wr_f), 8'd1);
        chk("decfsz_noskip_yet", 8'(skip), 8'd0);
        @(negedge clk);
        chk("decfsz_skip", 8'(skip), 8'd1);
        chk("decfsz_busy", 8'(bus.instr_ready), 8'd0);
        chk("decfsz_status", 8'(status), 8'h0);
        alu_zero = 1'b0;
        send(14'b001011_1_0001000);
        chk("gap_skip", 8'(hs_last - hs_prev), 8'd5);
        stat_wr = 1'b1; stat_din = 3'b010;
        @(negedge clk);
        stat_wr = 1'b0;
        @(negedge clk);
        chk("decfsz2_wrf", 8'(wr_f), 8'd1);
        @(negedge clk);
        chk("decfsz2_skip", 8'(skip), 8'd0);
        chk("decfsz2_status", 8'(status), 8'h2);
        // undecoded opcode
        send(14'b111111_1_0000001);
        chk("gap_noskip", 8'(hs_last - hs_prev), 8'd4);
        @(negedge clk);
        @(negedge clk);
        chk("illegal_pulse", 8'(illegal), 8'd1);
        chk("illegal_wrf", 8'(wr_f), 8'd0);
        chk("illegal_wrw", 8'(wr_w), 8'd0);
        @(negedge clk);
        chk("illegal_status", 8'(status), 8'h2);
        // ANDWF with a simultaneous external STATUS write in WB
        alu_zero = 1'b1; C_new = 1'b0; DC_new = 1'b0;
        send(14'b000101_0_0000010);
        chk("andwf_outmux", 8'(out_mux), 8'd2);
        chk("andwf_opl", 8'(op_mux_l), 8'd1);
        @(negedge clk);
        @(negedge clk);
        chk("andwf_wrw", 8'(wr_w), 8'd1);
        stat_wr = 1'b1; stat_din = 3'b011;
        @(negedge clk);
        stat_wr = 1'b0;
        chk("andwf_status", 8'(status), 8'h7);
        // randomized traffic, including occasional asynchronous resets
        repeat (800) begin
            @(negedge clk);
            op = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'($urandom_range(0, 15));
            bus.instr_valid = $urandom_range(0, 1) == 1;
            bus.instr = {op, 8'($urandom)};
            alu_zero = 1'($urandom);
            C_new = 1'($urandom);
            DC_new = 1'($urandom);
            stat_wr = $urandom_range(0, 7) == 0;
            stat_din = 3'($urandom);
            if ($urandom_range(0, 149) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                #2 rst_n = 1'b1;
            end
        end
        bus.instr_valid = 1'b0;
        stat_wr = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
